instr_mem_ctrl: RTL and testbench

//  Parametrised instruction memory for the multicycle core: byte-addressed, word-wide,

---
 rtl/instr_mem_ctrl_pkg.sv | 16 +
 rtl/instr_mem_ctrl_if.sv | 31 +++
 rtl/instr_mem_ctrl_array.sv | 24 ++
 rtl/instr_mem_ctrl.sv | 120 ++++++++++++
 tb/tb_instr_mem_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_mem_ctrl_pkg.sv
// Shared constants for the instruction memory controller: fault bit positions,
// default fault instruction and the controller state encoding.
package instr_mem_ctrl_pkg;

  localparam logic [31:0] NOP_WORD_DEF = 32'h2000_0000;

  localparam int FAULT_MISALIGN = 0;
  localparam int FAULT_RANGE    = 1;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_WAIT = 2'd1;
  localparam state_t ST_RESP = 2'd2;

endpackage

// File: rtl/instr_mem_ctrl_if.sv
// Fetch request/response and program-load bundle between fetch logic and the
// instruction memory controller.
interface instr_mem_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; valid never waits on ready, and the payload is held stable while valid=1
  // and ready=0. prog_we is a plain strobe with no ready.
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_instr;
  logic [1:0]        rsp_fault;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [DATA_W-1:0] prog_data;
  logic              prog_err;

  modport master (
    output req_valid, req_addr, rsp_ready, prog_we, prog_addr, prog_data,
    input  req_ready, rsp_valid, rsp_instr, rsp_fault, prog_err
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready, prog_we, prog_addr, prog_data,
    output req_ready, rsp_valid, rsp_instr, rsp_fault, prog_err
  );
endinterface

// File: rtl/instr_mem_ctrl_array.sv
// 1R1W synchronous instruction RAM, read-first on a same-address collision, no reset.
module instr_mem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int AW     = 8
) (
  input  logic              clk_i,
  input  logic              wr_en_i,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [AW-1:0]     rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Both updates are non-blocking, so a colliding read sees the pre-write word.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_o <= mem_q[rd_addr_i];
  end

endmodule

// File: rtl/instr_mem_ctrl.sv
// Instruction memory controller: one outstanding fetch with fixed read latency,
// fault decode for misaligned/out-of-range addresses, and a run-time program-load port.
module instr_mem_ctrl
  import instr_mem_ctrl_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 256,
  parameter int                ADDR_W   = 32,
  parameter int                READ_LAT = 1,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEF)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  instr_mem_ctrl_if.slave      bus,
  output state_t               state_o
);

  localparam int               AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int               IW        = ADDR_W - 2;
  localparam logic [IW-1:0]    DEPTH_IDX = IW'(DEPTH);
  localparam logic [1:0]       LAT_M1    = 2'(READ_LAT - 1);

  state_t            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [1:0]        fault_q, fault_d;
  logic              prog_err_q;

  logic [1:0]        req_fault;
  logic              prog_bad;
  logic              accept;
  logic              rd_en;
  logic [AW-1:0]     rd_addr;
  logic [DATA_W-1:0] rd_data;

  always_comb begin
    req_fault                 = '0;
    req_fault[FAULT_MISALIGN] = |bus.req_addr[1:0];
    req_fault[FAULT_RANGE]    = bus.req_addr[ADDR_W-1:2] >= DEPTH_IDX;
  end

  assign prog_bad      = (|bus.prog_addr[1:0]) || (bus.prog_addr[ADDR_W-1:2] >= DEPTH_IDX);
  // A program load owns the cycle: fetch acceptance is held off while prog_we is high.
  assign bus.req_ready = (state_q == ST_IDLE) && !bus.prog_we;
  assign accept        = bus.req_valid && bus.req_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    fault_d = fault_q;
    rd_en   = 1'b0;
    rd_addr = addr_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          addr_d  = bus.req_addr[AW+1:2];
          fault_d = req_fault;
          cnt_d   = LAT_M1;
          if (READ_LAT == 1) begin
            state_d = ST_RESP;
            rd_en   = ~|req_fault;
            rd_addr = bus.req_addr[AW+1:2];
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 2'd1;
        // The array is read on the last WAIT edge, so loads landing earlier are visible.
        if (cnt_q == 2'd1) begin
          state_d = ST_RESP;
          rd_en   = ~|fault_q;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      fault_q    <= '0;
      prog_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      fault_q    <= fault_d;
      prog_err_q <= bus.prog_we && prog_bad;
    end
  end

  instr_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_array (
    .clk_i     (clk),
    .wr_en_i   (bus.prog_we && !prog_bad),
    .wr_addr_i (bus.prog_addr[AW+1:2]),
    .wr_data_i (bus.prog_data),
    .rd_en_i   (rd_en),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_instr = !bus.rsp_valid ? '0 : ((|fault_q) ? NOP_WORD : rd_data);
  assign bus.rsp_fault = bus.rsp_valid ? fault_q : 2'b00;
  assign bus.prog_err  = prog_err_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Directed bench for instr_mem_ctrl: two instances (READ_LAT=1 and READ_LAT=3) driven
// from a fetch vector table plus hand-written multi-cycle sequences.
module tb_instr_mem_ctrl;
  import instr_mem_ctrl_pkg::*;

  localparam logic [31:0] NOP = 32'h2000_0000;

  logic   clk = 1'b0;
  logic   rst_n;
  state_t state1, state3;
  int     cyc = 0;
  int     tests_run = 0;
  int     fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  instr_mem_ctrl_if #(.ADDR_W(32), .DATA_W(32)) if1 ();
  instr_mem_ctrl_if #(.ADDR_W(32), .DATA_W(32)) if3 ();

  instr_mem_ctrl #(.DATA_W(32), .DEPTH(256), .ADDR_W(32), .READ_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave), .state_o(state1));
  instr_mem_ctrl #(.DATA_W(32), .DEPTH(256), .ADDR_W(32), .READ_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .bus(if3.slave), .state_o(state3));

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [1:0]  fault;
  } vec_t;
  vec_t vecs[9];

  // ---------------- accessors / drivers ----------------
  function automatic logic g_rdy(input int sel);
    return (sel == 1) ? if1.req_ready : if3.req_ready;
  endfunction
  function automatic logic g_rv(input int sel);
    return (sel == 1) ? if1.rsp_valid : if3.rsp_valid;
  endfunction
  function automatic logic [31:0] g_instr(input int sel);
    return (sel == 1) ? if1.rsp_instr : if3.rsp_instr;
  endfunction
  function automatic logic [1:0] g_flt(input int sel);
    return (sel == 1) ? if1.rsp_fault : if3.rsp_fault;
  endfunction
  function automatic logic g_perr(input int sel);
    return (sel == 1) ? if1.prog_err : if3.prog_err;
  endfunction
  function automatic state_t g_st(input int sel);
    return (sel == 1) ? state1 : state3;
  endfunction

  task automatic set_req(input int sel, input logic v, input logic [31:0] a);
    if (sel == 1) begin if1.req_valid = v; if1.req_addr = a; end
    else begin if3.req_valid = v; if3.req_addr = a; end
  endtask
  task automatic set_rspr(input int sel, input logic r);
    if (sel == 1) if1.rsp_ready = r; else if3.rsp_ready = r;
  endtask
  task automatic set_prog(input int sel, input logic we, input logic [31:0] a, input logic [31:0] d);
    if (sel == 1) begin if1.prog_we = we; if1.prog_addr = a; if1.prog_data = d; end
    else begin if3.prog_we = we; if3.prog_addr = a; if3.prog_data = d; end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // All tasks below are entered and (except where noted) left 1 time unit after a rising edge.
  task automatic start_fetch(input int sel, input logic [31:0] addr, output int waits, output bit ok);
    set_req(sel, 1'b1, addr);
    waits = 0;
    ok    = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (g_rdy(sel)) begin ok = 1'b1; break; end
      waits++;
    end
    if (!ok) begin
      check("fetch_accept_timeout", 32'd0, 32'd1);
      set_req(sel, 1'b0, '0);
      @(posedge clk); #1;
      return;
    end
    @(posedge clk); #1;
    set_req(sel, 1'b0, '0);
  endtask

  // Returns at the falling edge where rsp_valid is seen unless consume=1.
  task automatic wait_rsp(input int sel, input bit consume, output logic [31:0] instr,
                          output logic [1:0] flt, output int lat);
    lat   = 0;
    instr = '0;
    flt   = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (g_rv(sel)) break;
    end
    if (!g_rv(sel)) begin
      check("rsp_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      return;
    end
    instr = g_instr(sel);
    flt   = g_flt(sel);
    if (consume) begin @(posedge clk); #1; end
  endtask

  task automatic do_fetch(input int sel, input logic [31:0] addr, output logic [31:0] instr,
                          output logic [1:0] flt, output int lat);
    int w;
    bit ok;
    start_fetch(sel, addr, w, ok);
    instr = 'x; flt = 'x; lat = -1;
    if (ok) wait_rsp(sel, 1'b1, instr, flt, lat);
  endtask

  task automatic prog_write(input int sel, input logic [31:0] a, input logic [31:0] d,
                            output logic err, output logic err_next);
    set_prog(sel, 1'b1, a, d);
    @(posedge clk); #1;
    set_prog(sel, 1'b0, '0, '0);
    @(negedge clk);
    err = g_perr(sel);
    @(posedge clk); #1;
    err_next = g_perr(sel);
  endtask

  task automatic measure_period(input int sel, output int period);
    int t0, t1;
    bit got;
    logic [31:0] ins;
    logic [1:0]  f;
    int          l;
    period = -1;
    set_req(sel, 1'b1, 32'h0);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (g_rdy(sel)) begin got = 1'b1; break; end
    end
    t0 = cyc;
    @(posedge clk); #1;
    if (got) begin
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (g_rdy(sel)) begin got = 1'b1; break; end
      end
      t1 = cyc;
      @(posedge clk); #1;
      if (got) period = t1 - t0;
    end
    set_req(sel, 1'b0, '0);
    wait_rsp(sel, 1'b1, ins, f, l);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] ins;
    logic [1:0]  flt;
    int          lat, waits, hits;
    bit          ok;
    logic        e0, e1;

    vecs[0] = '{32'h0000_0004, 32'h2011_0007, 2'b00};
    vecs[1] = '{32'h0000_0000, 32'h2013_0001, 2'b00};
    vecs[2] = '{32'h0000_0008, 32'h2012_00AB, 2'b00};
    vecs[3] = '{32'h0000_03FC, 32'h2015_BEEF, 2'b00};
    vecs[4] = '{32'h0000_0006, NOP,           2'b01};
    vecs[5] = '{32'h0000_0400, NOP,           2'b10};
    vecs[6] = '{32'h0000_0402, NOP,           2'b11};
    vecs[7] = '{32'hFFFF_FFFC, NOP,           2'b10};
    vecs[8] = '{32'h0000_0001, NOP,           2'b01};

    // ---------------- clock/reset ----------------
    rst_n = 1'b0;
    for (int s = 1; s <= 3; s += 2) begin
      set_req(s, 1'b0, '0);
      set_rspr(s, 1'b1);
      set_prog(s, 1'b0, '0, '0);
    end
    #12;
    for (int s = 1; s <= 3; s += 2) begin
      check("reset_rsp_valid", 32'(g_rv(s)), 32'd0);
      check("reset_rsp_instr", g_instr(s), 32'd0);
      check("reset_rsp_fault", 32'(g_flt(s)), 32'd0);
      check("reset_prog_err", 32'(g_perr(s)), 32'd0);
      check("reset_state", 32'(g_st(s)), 32'(ST_IDLE));
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("idle_req_ready", 32'(g_rdy(1)), 32'd1);

    // ---------------- program load ----------------
    for (int s = 1; s <= 3; s += 2) begin
      prog_write(s, 32'h0, 32'h2013_0001, e0, e1);
      check("load_ok_err", 32'(e0), 32'd0);
      prog_write(s, 32'h4, 32'h2011_0007, e0, e1);
      prog_write(s, 32'h8, 32'h2012_00AB, e0, e1);
      prog_write(s, 32'h3FC, 32'h2015_BEEF, e0, e1);
    end

    // ---------------- vector table on both latencies ----------------
    for (int s = 1; s <= 3; s += 2) begin
      for (int i = 0; i < 9; i++) begin
        do_fetch(s, vecs[i].addr, ins, flt, lat);
        check($sformatf("vec%0d_lat%0d_instr", i, s), ins, vecs[i].instr);
        check($sformatf("vec%0d_lat%0d_fault", i, s), 32'(flt), 32'(vecs[i].fault));
        check($sformatf("vec%0d_lat%0d_latency", i, s), 32'(lat), 32'(s));
      end
    end

    // ---------------- bad program loads ----------------
    prog_write(1, 32'h400, 32'h1111_1111, e0, e1);
    check("prog_range_err", 32'(e0), 32'd1);
    check("prog_err_pulse", 32'(e1), 32'd0);
    prog_write(1, 32'h2, 32'h2222_2222, e0, e1);
    check("prog_misalign_err", 32'(e0), 32'd1);
    prog_write(1, 32'h10, 32'h2016_0010, e0, e1);
    check("prog_good_err", 32'(e0), 32'd0);
    do_fetch(1, 32'h0, ins, flt, lat);
    check("bad_load_no_alias", ins, 32'h2013_0001);
    do_fetch(1, 32'h10, ins, flt, lat);
    check("good_load_readback", ins, 32'h2016_0010);

    // ---------------- throughput ----------------
    measure_period(1, lat);
    check("period_lat1", 32'(lat), 32'd2);
    measure_period(3, lat);
    check("period_lat3", 32'(lat), 32'd4);

    // ---------------- backpressure, READ_LAT=3 ----------------
    set_rspr(3, 1'b0);
    start_fetch(3, 32'h4, waits, ok);
    wait_rsp(3, 1'b0, ins, flt, lat);
    check("bp_latency", 32'(lat), 32'd3);
    check("bp_instr", ins, 32'h2011_0007);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_valid", 32'(g_rv(3)), 32'd1);
      check("bp_hold_instr", g_instr(3), 32'h2011_0007);
      check("bp_hold_ready", 32'(g_rdy(3)), 32'd0);
    end
    set_rspr(3, 1'b1);
    @(negedge clk);
    check("bp_release_valid", 32'(g_rv(3)), 32'd0);
    check("bp_release_ready", 32'(g_rdy(3)), 32'd1);
    @(posedge clk); #1;

    // ---------------- load and fetch in the same IDLE cycle ----------------
    set_prog(1, 1'b1, 32'h14, 32'h2017_0014);
    set_req(1, 1'b1, 32'h14);
    @(negedge clk);
    check("load_wins_ready", 32'(g_rdy(1)), 32'd0);
    @(posedge clk); #1;
    set_prog(1, 1'b0, '0, '0);
    start_fetch(1, 32'h14, waits, ok);
    check("load_then_accept_wait", 32'(waits), 32'd0);
    wait_rsp(1, 1'b1, ins, flt, lat);
    check("load_then_fetch_instr", ins, 32'h2017_0014);

    // ---------------- write to an in-flight fetch address ----------------
    start_fetch(3, 32'h8, waits, ok);
    set_prog(3, 1'b1, 32'h8, 32'h2018_AAAA);
    @(posedge clk); #1;
    set_prog(3, 1'b0, '0, '0);
    wait_rsp(3, 1'b1, ins, flt, lat);
    check("inflight_early_write_new", ins, 32'h2018_AAAA);

    start_fetch(3, 32'h8, waits, ok);
    @(posedge clk); #1;
    set_prog(3, 1'b1, 32'h8, 32'h2019_BBBB);
    @(posedge clk); #1;
    set_prog(3, 1'b0, '0, '0);
    wait_rsp(3, 1'b1, ins, flt, lat);
    check("inflight_same_edge_old", ins, 32'h2018_AAAA);
    do_fetch(3, 32'h8, ins, flt, lat);
    check("inflight_same_edge_stored", ins, 32'h2019_BBBB);

    start_fetch(1, 32'h8, waits, ok);
    set_prog(1, 1'b1, 32'h8, 32'h201A_CCCC);
    @(negedge clk);
    check("lat1_late_write_valid", 32'(g_rv(1)), 32'd1);
    check("lat1_late_write_old", g_instr(1), 32'h2012_00AB);
    @(posedge clk); #1;
    set_prog(1, 1'b0, '0, '0);
    do_fetch(1, 32'h8, ins, flt, lat);
    check("lat1_late_write_stored", ins, 32'h201A_CCCC);

    // ---------------- reset during WAIT ----------------
    start_fetch(3, 32'h4, waits, ok);
    @(negedge clk);
    check("pre_reset_in_wait", 32'(g_st(3)), 32'(ST_WAIT));
    rst_n = 1'b0;
    #1;
    check("mid_reset_valid", 32'(g_rv(3)), 32'd0);
    check("mid_reset_state", 32'(g_st(3)), 32'(ST_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    hits = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (g_rv(3)) hits++;
    end
    check("post_reset_no_rsp", 32'(hits), 32'd0);
    @(posedge clk); #1;
    do_fetch(3, 32'h4, ins, flt, lat);
    check("post_reset_mem_4", ins, 32'h2011_0007);
    do_fetch(3, 32'h0, ins, flt, lat);
    check("post_reset_mem_0", ins, 32'h2013_0001);
    do_fetch(1, 32'h10, ins, flt, lat);
    check("post_reset_mem_lat1", ins, 32'h2016_0010);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
